// File: rtl/aes128_task_feeder.sv
// Task FIFO and launch sequencer feeding {key, plaintext} jobs to the AES-128 control block.
// Optional start-to-done watchdog is compiled in with `define FEEDER_TIMEOUT_EN.
module aes128_task_feeder #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_key_i,
    input  logic [127:0] in_data_i,
    input  logic         core_ready_i,
    input  logic         core_done_i,
    output logic         core_start_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_data_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [127:0] key_mem  [DEPTH];
    logic [127:0] data_mem [DEPTH];

    state_t       state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic         start_q, start_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;
    logic         push, pop;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness uses the pre-pop count, so a full FIFO refuses a push even while popping.
    assign in_ready_o   = (count_q < CW'(DEPTH));
    assign push         = in_valid_i && in_ready_o;

    assign core_start_o = start_q;
    assign core_key_o   = key_q;
    assign core_data_o  = data_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        start_d  = 1'b0;
        key_d    = key_q;
        data_d   = data_q;
        busy_d   = busy_q;
        err_d    = err_q;
        pop      = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        timer_d  = timer_q;
`endif

        case (state_q)
            IDLE: begin
                if (core_done_i) begin
                    err_d = 1'b1;
                end else if ((count_q != '0) && core_ready_i && !err_q) begin
                    state_d = BUSY;
                    start_d = 1'b1;
                    key_d   = key_mem[rd_ptr_q];
                    data_d  = data_mem[rd_ptr_q];
                    busy_d  = 1'b1;
`ifdef FEEDER_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            BUSY: begin
                if (core_done_i) begin
                    pop     = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef FEEDER_TIMEOUT_EN
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Next value would reach TIMEOUT: drop the stuck task and flag it.
                    pop     = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (srst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            key_q    <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            start_q  <= start_d;
            key_q    <= key_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
`ifdef FEEDER_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            key_mem[wr_ptr_q]  <= in_key_i;
            data_mem[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_aes128_task_feeder.sv
// Self-checking bench for aes128_task_feeder: directed table, corner sequences, random vs queue model.
// Define FEEDER_TIMEOUT_EN for both files to exercise the watchdog.
module tb_aes128_task_feeder;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         srst, in_valid, core_ready, core_done;
    logic [127:0] in_key, in_data;
    logic         in_ready, core_start, busy, err;
    logic [127:0] core_key, core_data;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: a queue of pending tasks plus launch/err status.
    logic [255:0] m_q[$];
    logic         m_busy, m_start, m_err;
    logic [127:0] m_key, m_data;
    int           m_age;

    always #5 clk = ~clk;

    aes128_task_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .srst_i(srst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_key_i(in_key), .in_data_i(in_data),
        .core_ready_i(core_ready), .core_done_i(core_done),
        .core_start_o(core_start), .core_key_o(core_key), .core_data_o(core_data),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        logic         valid;
        logic [127:0] key, data;
        logic         rdy, done;
        logic         exp_in_ready, exp_start, exp_busy, chk_key;
        logic [127:0] exp_key, exp_data;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit push_ok;
        push_ok = in_valid && (m_q.size() < DEPTH);
        if (srst) begin
            m_q.delete();
            m_busy = 0; m_start = 0; m_err = 0; m_key = '0; m_data = '0; m_age = 0;
            return;
        end
        m_start = 0;
        if (!m_busy) begin
            if (core_done) m_err = 1;
            else if (m_q.size() > 0 && core_ready && !m_err) begin
                m_busy = 1; m_start = 1; {m_key, m_data} = m_q[0]; m_age = 0;
            end
        end else begin
            if (core_done) begin
                void'(m_q.pop_front()); m_busy = 0;
            end
`ifdef FEEDER_TIMEOUT_EN
            else if (m_age == TIMEOUT - 1) begin
                void'(m_q.pop_front()); m_busy = 0; m_err = 1;
            end else m_age++;
`endif
        end
        if (push_ok) m_q.push_back({in_key, in_data});
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk); #1;
        check("m_in_ready", in_ready, (m_q.size() < DEPTH));
        check("m_start", core_start, m_start);
        check("m_busy", busy, m_busy);
        check("m_err", err, m_err);
        check("m_key", core_key, m_key);
        check("m_data", core_data, m_data);
    endtask

    task automatic idle_inputs();
        srst = 0; in_valid = 0; core_ready = 0; core_done = 0; in_key = '0; in_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        srst = 1;
        cycle();
        srst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_start", core_start, 0);
        check("rst_key", core_key, 0);
        check("rst_data", core_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    task automatic push_one(input logic [127:0] k, input logic [127:0] d);
        in_valid = 1; in_key = k; in_data = d;
        cycle();
        in_valid = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;

    vec_t vt[5];
    logic [127:0] seen[$];
    int   budget;

    initial begin
        idle_inputs();
        m_q.delete(); m_busy = 0; m_start = 0; m_err = 0; m_key = '0; m_data = '0; m_age = 0;

        // Single task: launch two edges after the push, held until done, busy drops after done.
        vt[0] = '{1, K0, P0, 1, 0, 1, 0, 0, 1, 128'h0, 128'h0};
        vt[1] = '{0, 0,  0,  1, 0, 1, 1, 1, 1, K0, P0};
        vt[2] = '{0, 0,  0,  1, 0, 1, 0, 1, 1, K0, P0};
        vt[3] = '{0, 0,  0,  1, 1, 1, 0, 0, 0, K0, P0};
        vt[4] = '{0, 0,  0,  1, 0, 1, 0, 0, 0, K0, P0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = vt[i].valid; in_key = vt[i].key; in_data = vt[i].data;
            core_ready = vt[i].rdy; core_done = vt[i].done;
            cycle();
            check($sformatf("vec%0d_in_ready", i), in_ready, vt[i].exp_in_ready);
            check($sformatf("vec%0d_start", i), core_start, vt[i].exp_start);
            check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
            if (vt[i].chk_key) begin
                check($sformatf("vec%0d_key", i), core_key, vt[i].exp_key);
                check($sformatf("vec%0d_data", i), core_data, vt[i].exp_data);
            end
        end
        idle_inputs();

        // Overfill with core stalled, then drain with done 13 cycles after each start.
        do_reset();
        push_one(128'hA, 128'h1A);
        check("fill1_ready", in_ready, 1);
        push_one(128'hB, 128'h1B);
        check("fill2_ready", in_ready, 0);
        push_one(128'hC, 128'h1C);
        check("fill3_ready", in_ready, 0);
        core_ready = 1;
        seen.delete();
        budget = 0;
        while (budget < 80) begin
            cycle(); budget++;
            if (core_start) begin
                seen.push_back(core_key);
                for (int j = 0; j < 12; j++) cycle();
                core_done = 1; cycle(); core_done = 0;
                budget += 13;
            end
        end
        check("drain_launches", seen.size(), 2);
        if (seen.size() >= 2) begin
            check("drain_first", seen[0], 128'hA);
            check("drain_second", seen[1], 128'hB);
        end
        idle_inputs();

        // Full FIFO: done and push in the same cycle -> push refused, accepted next cycle.
        do_reset();
        core_ready = 1;
        push_one(128'h10, 128'h20);
        cycle();
        check("full_launch_busy", busy, 1);
        push_one(128'h11, 128'h21);
        check("full_ready_low", in_ready, 0);
        in_valid = 1; in_key = 128'h12; in_data = 128'h22; core_done = 1;
        cycle();
        core_done = 0;
        check("same_cycle_ready", in_ready, 1);
        cycle();
        in_valid = 0;
        check("push_next_full", in_ready, 0);
        check("model_count_two", m_q.size(), 2);
        for (int j = 0; j < 4; j++) cycle();
        check("second_head_key", core_key, 128'h11);
        idle_inputs();

        // Spurious done sets sticky err; queued work never launches; reset clears all.
        do_reset();
        core_done = 1; cycle(); core_done = 0;
        check("spurious_err", err, 1);
        core_ready = 1;
        push_one(rnd128(), rnd128());
        push_one(rnd128(), rnd128());
        check("err_fifo_full", in_ready, 0);
        for (int j = 0; j < 10; j++) begin
            cycle();
            check("err_no_start", core_start, 0);
        end
        srst = 1; cycle(); srst = 0;
        check("err_cleared", err, 0);
        check("fifo_cleared", in_ready, 1);
        for (int j = 0; j < 3; j++) cycle();
        check("no_stale_launch", busy, 0);
        idle_inputs();

        // Reset five cycles into BUSY, then a fresh task launches normally.
        do_reset();
        core_ready = 1;
        push_one(128'h55, 128'h66);
        cycle();
        for (int j = 0; j < 5; j++) cycle();
        srst = 1; cycle(); srst = 0;
        check("midrst_busy", busy, 0);
        check("midrst_key", core_key, 0);
        check("midrst_ready", in_ready, 1);
        push_one(128'h77, 128'h88);
        cycle();
        check("post_rst_start", core_start, 1);
        check("post_rst_key", core_key, 128'h77);
        core_done = 1; cycle(); core_done = 0;
        idle_inputs();

`ifdef FEEDER_TIMEOUT_EN
        // Withheld done: watchdog fires exactly TIMEOUT cycles after the start pulse.
        do_reset();
        core_ready = 1;
        push_one(128'h99, 128'hAA);
        push_one(128'h9A, 128'hAB);
        cycle();
        check("to_start", core_start, 1);
        core_ready = 0;
        for (int j = 1; j < TIMEOUT; j++) cycle();
        check("to_not_yet", err, 0);
        cycle();
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_popped", in_ready, 1);
        idle_inputs();
`endif

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            srst       = ($urandom_range(0, 149) == 0) || (m_err && $urandom_range(0, 19) == 0);
            in_valid   = $urandom_range(0, 1);
            in_key     = rnd128();
            in_data    = rnd128();
            core_ready = ($urandom_range(0, 3) != 0);
            core_done  = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
